// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path.
//   DATA_W_DEF : default sample word width
//   FL_*       : bit positions in the flags/status register
//   ptr_w()    : FIFO pointer width (address bits plus one wrap bit)
package i2s_pkg;

   localparam int unsigned DATA_W_DEF = 32;

   localparam int unsigned FL_FULL   = 0;
   localparam int unsigned FL_EMPTY  = 1;
   localparam int unsigned FL_AFULL  = 2;
   localparam int unsigned FL_AEMPTY = 3;
   localparam int unsigned FL_OVF    = 4;
   localparam int unsigned FL_UDF    = 5;
   localparam int unsigned FL_W      = 6;

   typedef logic [FL_W-1:0] flags_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage for the transmit FIFO.
//   pclk, preset : clock, async active-low reset (read register only)
//   we, waddr, wdata : synchronous write port
//   re, raddr    : read request and address
//   rdata        : registered read word, holds when re is low
// Storage itself is not reset.
module fifo_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                       pclk,
   input  logic                       preset,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       re,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]          rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge pclk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Same-address write and read returns the old word.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/i2s_tx_fifo.sv
// Transmit-sample FIFO between the APB control stage and the I2S serializer.
//   pclk, preset   : clock, async active-low reset
//   flush          : sync clear of pointers, level and rvalid
//   clr_sticky     : sync clear of overflow/underflow
//   wen, wdata     : write request and word
//   ren            : read request from serializer
//   rdata, rvalid  : registered read word and its one-cycle valid pulse
//   full, empty, almost_full, almost_empty, level : occupancy status
//   overflow, underflow : sticky error flags
module i2s_tx_fifo
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 8,   // power of two, >= 4
   parameter int unsigned AF_LVL = 6,
   parameter int unsigned AE_LVL = 2
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      flush,
   input  logic                      clr_sticky,
   input  logic                      wen,
   input  logic [DATA_W-1:0]         wdata,
   input  logic                      ren,
   output logic [DATA_W-1:0]         rdata,
   output logic                      rvalid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned AW = PW - 1;

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] level_q, level_d;
   logic          rvalid_q, rvalid_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;

   logic   ptr_full, ptr_empty;
   logic   ren_acc, wen_acc;
   flags_t flags;

   // Wrap bit distinguishes full from empty when addresses match.
   assign ptr_empty = (wptr_q == rptr_q);
   assign ptr_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

   // A write into a full FIFO is allowed when a read frees a slot on the same edge.
   assign ren_acc = ren && !ptr_empty && !flush;
   assign wen_acc = wen && (!ptr_full || ren_acc) && !flush;

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      level_d  = level_q;
      rvalid_d = ren_acc;

      if (flush) begin
         wptr_d   = '0;
         rptr_d   = '0;
         level_d  = '0;
         rvalid_d = 1'b0;
      end else begin
         if (wen_acc) wptr_d = wptr_q + PW'(1);
         if (ren_acc) rptr_d = rptr_q + PW'(1);
         unique case ({wen_acc, ren_acc})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Sticky error flags: set dominates clear; flush leaves them alone.
   always_comb begin
      ovf_d = ovf_q && !clr_sticky;
      udf_d = udf_q && !clr_sticky;
      if (!flush && wen && ptr_full && !ren) ovf_d = 1'b1;
      if (!flush && ren && ptr_empty)        udf_d = 1'b1;
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         rvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         rvalid_q <= rvalid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .pclk   (pclk),
      .preset (preset),
      .we     (wen_acc),
      .waddr  (wptr_q[AW-1:0]),
      .wdata  (wdata),
      .re     (ren_acc),
      .raddr  (rptr_q[AW-1:0]),
      .rdata  (rdata)
   );

   // Status is decoded from the registered level so it lines up with the flags register.
   always_comb begin
      flags            = '0;
      flags[FL_FULL]   = (level_q == PW'(DEPTH));
      flags[FL_EMPTY]  = (level_q == '0);
      flags[FL_AFULL]  = (level_q >= PW'(AF_LVL));
      flags[FL_AEMPTY] = (level_q <= PW'(AE_LVL));
      flags[FL_OVF]    = ovf_q;
      flags[FL_UDF]    = udf_q;
   end

   assign full         = flags[FL_FULL];
   assign empty        = flags[FL_EMPTY];
   assign almost_full  = flags[FL_AFULL];
   assign almost_empty = flags[FL_AEMPTY];
   assign overflow     = flags[FL_OVF];
   assign underflow    = flags[FL_UDF];
   assign level        = level_q;
   assign rvalid       = rvalid_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Self-checking bench for i2s_tx_fifo: a vector table for the fill/overflow/drain
// sequence, then hand-written sequences for the multi-cycle corner cases.
module tb_i2s_tx_fifo;

   logic        pclk;
   logic        preset;
   logic        flush;
   logic        clr_sticky;
   logic        wen;
   logic [31:0] wdata;
   logic        ren;
   logic [31:0] rdata;
   logic        rvalid;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic        almost_empty;
   logic [3:0]  level;
   logic        overflow;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   i2s_tx_fifo dut (
      .pclk         (pclk),
      .preset       (preset),
      .flush        (flush),
      .clr_sticky   (clr_sticky),
      .wen          (wen),
      .wdata        (wdata),
      .ren          (ren),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct {
      logic        w;
      logic        r;
      logic        f;
      logic        c;
      logic [31:0] wd;
      logic [3:0]  lvl;
      logic        rv;
      logic [31:0] rd;
      logic        ovf;
      logic        udf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic w, input logic r, input logic f, input logic c,
                               input logic [31:0] wd, input logic [3:0] lvl, input logic rv,
                               input logic [31:0] rd, input logic ovf, input logic udf);
      vec_t v;
      v.w = w; v.r = r; v.f = f; v.c = c; v.wd = wd;
      v.lvl = lvl; v.rv = rv; v.rd = rd; v.ovf = ovf; v.udf = udf;
      return v;
   endfunction

   // Expected packed observation; flags follow from the level thresholds 8/0/>=6/<=2.
   function automatic logic [42:0] pack_exp(input logic [3:0] lvl, input logic rv,
                                            input logic [31:0] rd, input logic ovf,
                                            input logic udf);
      return {lvl, (lvl == 4'd8), (lvl == 4'd0), (lvl >= 4'd6), (lvl <= 4'd2), rv, rd, ovf, udf};
   endfunction

   function automatic logic [42:0] pack_act();
      return {level, full, empty, almost_full, almost_empty, rvalid, rdata, overflow, underflow};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic [31:0] wd);
      wen = w; ren = r; wdata = wd; flush = 1'b0; clr_sticky = 1'b0;
   endtask

   logic [31:0] model[$];
   logic [31:0] exp_d;

   initial begin
      preset = 1'b0; flush = 1'b0; clr_sticky = 1'b0;
      wen = 1'b0; ren = 1'b0; wdata = '0;

      // Fill, overflow attempt, full drain, idle, sticky clear.
      tbl.push_back(mk(0, 0, 0, 0, 0, 4'd0, 0, 32'h0, 0, 0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1, 0, 0, 0, 32'hA0 + i, 4'(i + 1), 0, 32'h0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 32'hFF, 4'd8, 0, 32'h0, 1, 0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 1, 0, 0, 0, 4'(7 - i), 1, 32'hA0 + i, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 4'd0, 0, 32'hA7, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 4'd0, 0, 32'hA7, 0, 0));

      repeat (2) step();
      chk("reset_state", 64'(pack_act()), 64'(pack_exp(4'd0, 0, 32'h0, 0, 0)));
      preset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         wen = tbl[i].w; ren = tbl[i].r; flush = tbl[i].f; clr_sticky = tbl[i].c;
         wdata = tbl[i].wd;
         step();
         chk($sformatf("vec%0d", i), 64'(pack_act()),
             64'(pack_exp(tbl[i].lvl, tbl[i].rv, tbl[i].rd, tbl[i].ovf, tbl[i].udf)));
      end

      // Full FIFO: simultaneous write and read both accepted.
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 32'hA0 + i);
         step();
      end
      chk("full_before_rw", 64'({level, full}), 64'({4'd8, 1'b1}));
      drive(1, 1, 32'hB0);
      step();
      chk("full_rw", 64'({rdata, rvalid, level, overflow}), 64'({32'hA0, 1'b1, 4'd8, 1'b0}));
      for (int i = 0; i < 8; i++) begin
         exp_d = (i < 7) ? 32'hA1 + i : 32'hB0;
         drive(0, 1, 0);
         step();
         chk($sformatf("drain_rw%0d", i), 64'({rdata, rvalid}), 64'({exp_d, 1'b1}));
      end
      chk("drain_rw_empty", 64'({empty, level}), 64'({1'b1, 4'd0}));

      // Empty FIFO: write accepted, read rejected, no fall-through.
      drive(1, 1, 32'hC0);
      step();
      chk("empty_rw", 64'({underflow, rvalid, level}), 64'({1'b1, 1'b0, 4'd1}));
      drive(0, 1, 0);
      step();
      chk("empty_rw_read", 64'({rdata, rvalid, level}), 64'({32'hC0, 1'b1, 4'd0}));

      // Wrap: hold level at 3 across 20 write/read pairs.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 32'hD0 + i);
         model.push_back(32'hD0 + i);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 32'h100 + i);
         exp_d = model.pop_front();
         model.push_back(32'h100 + i);
         step();
         chk($sformatf("wrap%0d", i), 64'({rdata, rvalid, level, full, empty}),
             64'({exp_d, 1'b1, 4'd3, 1'b0, 1'b0}));
      end
      drive(0, 0, 0);
      clr_sticky = 1'b1;
      step();
      chk("clr_sticky", 64'({overflow, underflow}), 64'({1'b0, 1'b0}));
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0);
         exp_d = model.pop_front();
         step();
         chk($sformatf("wrap_drain%0d", i), 64'({rdata, rvalid}), 64'({exp_d, 1'b1}));
      end

      // Flush at level 5 with underflow already set; flush overrides wen/ren.
      drive(0, 1, 0);
      step();
      chk("udf_set", 64'(underflow), 64'(1'b1));
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 32'hE0 + i);
         step();
      end
      chk("level5", 64'(level), 64'(4'd5));
      drive(1, 1, 32'hEE);
      flush = 1'b1;
      step();
      chk("flush", 64'({level, empty, rvalid, overflow, underflow}),
          64'({4'd0, 1'b1, 1'b0, 1'b0, 1'b1}));
      drive(0, 0, 0);
      step();
      chk("flush_idle", 64'({level, empty}), 64'({4'd0, 1'b1}));

      // Async reset in the middle of a write.
      drive(1, 0, 32'hF0);
      step();
      drive(0, 1, 0);
      step();
      chk("pre_reset_read", 64'({rdata, rvalid}), 64'({32'hF0, 1'b1}));
      drive(1, 0, 32'hF5);
      #2;
      preset = 1'b0;
      #1;
      chk("async_reset", 64'(pack_act()), 64'(pack_exp(4'd0, 0, 32'h0, 0, 0)));
      #3;
      preset = 1'b1;
      drive(0, 0, 0);
      step();
      chk("post_reset", 64'({level, empty, rvalid, rdata}), 64'({4'd0, 1'b1, 1'b0, 32'h0}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
